// File: rtl/game_pkg.sv
// Purpose: shared tile codes, playfield geometry, movement state codes and tile helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package game_pkg;

    // Tile codes as stored in the background map
    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;

    // Geometry in pixels
    localparam int CHARACTER_WIDTH = 42;
    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;
    localparam int BLOCK_WIDTH     = 40;
    localparam int STARTX          = 40;
    localparam int STARTY          = 398;
    localparam int JUMP_HEIGHT     = 100;
    localparam int BOUNCE_HEIGHT   = 40;

    // Grid extent: 12 rows, 17 columns (one column beyond the right screen edge)
    localparam int GRID_ROWS = SCREEN_HEIGHT / BLOCK_WIDTH;
    localparam int GRID_COLS = SCREEN_WIDTH / BLOCK_WIDTH + 1;

    // Movement states; the code doubles as the LED bit index, so the Goomba
    // walker's LED decoding can share it
    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_GROUND = 3'd1;
    localparam logic [2:0] ST_RISE   = 3'd2;
    localparam logic [2:0] ST_FALL   = 3'd3;
    localparam logic [2:0] ST_BOUNCE = 3'd4;
    localparam logic [2:0] ST_DEAD   = 3'd5;

    typedef logic [11:0][16:0][7:0] tile_map_t;

    function automatic logic is_solid(input logic [7:0] tile);
        return (tile == BLK) || (tile == GND);
    endfunction

    // Pin a signed grid coordinate into 0..hi
    function automatic int clamp_idx(input int v, input int hi);
        if (v < 0)
            return 0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/tile_probe.sv
// Purpose: clamped tile lookups just outside each edge of a 42 px sprite; reports solid neighbours.
// Latency: combinational.
// Backpressure: none.
module tile_probe
    import game_pkg::*;
(
    input  logic signed [31:0] pos_x,
    input  logic signed [31:0] pos_y,
    input  tile_map_t          background,
    output logic               solid_left,
    output logic               solid_right,
    output logic               solid_above,
    output logic               solid_below
);

    logic [4:0] col_left;
    logic [4:0] col_right;
    logic [3:0] row_above;
    logic [3:0] row_below;
    logic [3:0] row_top;
    logic [3:0] row_bottom;

    // Grid cells one pixel outside each sprite edge, plus the rows spanned by the sprite
    always_comb begin
        col_left   = 5'(clamp_idx((pos_x - 1) / BLOCK_WIDTH, GRID_COLS - 1));
        col_right  = 5'(clamp_idx((pos_x + CHARACTER_WIDTH) / BLOCK_WIDTH, GRID_COLS - 1));
        row_above  = 4'(clamp_idx((pos_y - 1) / BLOCK_WIDTH, GRID_ROWS - 1));
        row_below  = 4'(clamp_idx((pos_y + CHARACTER_WIDTH) / BLOCK_WIDTH, GRID_ROWS - 1));
        row_top    = 4'(clamp_idx(pos_y / BLOCK_WIDTH, GRID_ROWS - 1));
        row_bottom = 4'(clamp_idx((pos_y + CHARACTER_WIDTH - 1) / BLOCK_WIDTH, GRID_ROWS - 1));
    end

    // A direction is blocked if either of its two corner probes hits a solid tile
    always_comb begin
        solid_left  = is_solid(background[row_top][col_left])   || is_solid(background[row_bottom][col_left]);
        solid_right = is_solid(background[row_top][col_right])  || is_solid(background[row_bottom][col_right]);
        solid_above = is_solid(background[row_above][col_left]) || is_solid(background[row_above][col_right]);
        solid_below = is_solid(background[row_below][col_left]) || is_solid(background[row_below][col_right]);
    end

endmodule

// File: rtl/mario_motion_controller.sv
// Purpose: player movement FSM (walk, jump, fall, stomp-bounce, death) producing position and stomp pulse.
// Latency: all outputs registered; inputs act on the next movement_clock edge.
// Backpressure: none; state advances every tick.
module mario_motion_controller
    import game_pkg::*;
(
    input  logic               movement_clock,
    input  logic               reset,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_jump,
    input  tile_map_t          background,
    input  logic signed [31:0] goomba_x,
    input  logic signed [31:0] goomba_y,
    input  logic               lose,
    output logic signed [31:0] mario_x,
    output logic signed [31:0] mario_y,
    output logic               stomp,
    output logic               dead,
    output logic [5:0]         state_leds
);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [6:0]         rise_cnt;
    logic [6:0]         rise_cnt_nxt;
    logic signed [31:0] x_nxt;
    logic signed [31:0] y_nxt;
    logic signed [31:0] x_step;
    logic               stomp_nxt;
    logic               solid_left;
    logic               solid_right;
    logic               solid_above;
    logic               solid_below;
    logic               goomba_hit;

    tile_probe u_probe (
        .pos_x       (mario_x),
        .pos_y       (mario_y),
        .background  (background),
        .solid_left  (solid_left),
        .solid_right (solid_right),
        .solid_above (solid_above),
        .solid_below (solid_below)
    );

    // Feet exactly on the Goomba's head with horizontal overlap; a removed Goomba never counts
    assign goomba_hit = (goomba_x < SCREEN_WIDTH)
                     && (mario_x + CHARACTER_WIDTH >= goomba_x)
                     && (mario_x <= goomba_x + CHARACTER_WIDTH)
                     && (mario_y + CHARACTER_WIDTH == goomba_y);

    // Status outputs decode straight from the state register
    assign dead       = (state == ST_DEAD);
    assign state_leds = 6'b000001 << state;

    // Horizontal step shared by every live state; both buttons cancel out
    always_comb begin
        x_step = mario_x;
        if (btn_left && !btn_right && (mario_x > 0) && !solid_left)
            x_step = mario_x - 1;
        else if (btn_right && !btn_left && (mario_x + CHARACTER_WIDTH < SCREEN_WIDTH) && !solid_right)
            x_step = mario_x + 1;
    end

    // Next-state logic; Goomba contact overrides everything outside RESET
    always_comb begin
        state_nxt    = state;
        x_nxt        = mario_x;
        y_nxt        = mario_y;
        rise_cnt_nxt = rise_cnt;
        stomp_nxt    = 1'b0;
        case (state)
            ST_RESET: begin
                x_nxt        = STARTX;
                y_nxt        = STARTY;
                rise_cnt_nxt = '0;
                state_nxt    = ST_GROUND;
            end
            ST_GROUND: begin
                x_nxt = x_step;
                if (!solid_below) begin
                    state_nxt = ST_FALL;
                end else if (btn_jump) begin
                    state_nxt    = ST_RISE;
                    rise_cnt_nxt = 7'(JUMP_HEIGHT);
                end
            end
            ST_RISE, ST_BOUNCE: begin
                x_nxt = x_step;
                if ((rise_cnt == '0) || solid_above || (mario_y <= 0)) begin
                    state_nxt = ST_FALL;
                end else begin
                    y_nxt        = mario_y - 1;
                    rise_cnt_nxt = rise_cnt - 7'd1;
                    // Last step of the climb hands over to FALL in the same tick
                    if (rise_cnt == 7'd1)
                        state_nxt = ST_FALL;
                end
            end
            ST_FALL: begin
                x_nxt = x_step;
                if (goomba_hit) begin
                    stomp_nxt    = 1'b1;
                    state_nxt    = ST_BOUNCE;
                    rise_cnt_nxt = 7'(BOUNCE_HEIGHT);
                end else if (solid_below) begin
                    state_nxt = ST_GROUND;
                end else begin
                    y_nxt = mario_y + 1;
                end
            end
            default: begin
                // DEAD: position frozen until reset
            end
        endcase
        if (lose && (state != ST_RESET)) begin
            state_nxt    = ST_DEAD;
            x_nxt        = mario_x;
            y_nxt        = mario_y;
            rise_cnt_nxt = rise_cnt;
            stomp_nxt    = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_RESET;
            mario_x  <= STARTX;
            mario_y  <= STARTY;
            rise_cnt <= '0;
            stomp    <= 1'b0;
        end else begin
            state    <= state_nxt;
            mario_x  <= x_nxt;
            mario_y  <= y_nxt;
            rise_cnt <= rise_cnt_nxt;
            stomp    <= stomp_nxt;
        end
    end

endmodule
